dma_axi_wr_arbiter: RTL and testbench



---
 rtl/dma_arb_pkg.sv | 40 ++++
 rtl/dma_outst_cnt.sv | 28 ++
 rtl/dma_axi_wr_arbiter.sv | 170 +++++++++++++++++
 tb/tb_dma_axi_wr_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_arb_pkg.sv
// Shared types, constants and the round-robin pick helper for the DMA write arbiter.
`timescale 1ns/1ps
package dma_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int LEN_BITS  = 4;
  localparam int SIZE_BITS = 3;

  // Upper bound on channel count the pick helper can scan.
  localparam int MAX_CH   = 16;
  localparam int MAX_CH_W = 4;

  // First requesting index at or after ptr, wrapping modulo n; returns ptr if none request.
  function automatic int unsigned rr_pick(input logic [MAX_CH-1:0] req,
                                          input int unsigned       ptr,
                                          input int unsigned       n);
    int unsigned idx;
    logic        found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned k = 0; k < MAX_CH; k++) begin
      if (!found && k < n) begin
        idx = (ptr + k) % n;
        if (req[idx[MAX_CH_W-1:0]]) begin
          rr_pick = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/dma_outst_cnt.sv
// Per-channel outstanding-burst counter; saturates at both ends, simultaneous inc/dec holds.
`timescale 1ns/1ps
module dma_outst_cnt #(
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec && r_cnt != CNT_W'(MAX_OUTST)) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (i_dec && !i_inc && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_full = (r_cnt == CNT_W'(MAX_OUTST));

endmodule

// File: rtl/dma_axi_wr_arbiter.sv
// Shares one 64-bit AXI3 write master between NUM_CH DMA write engines (AW then W per burst).
// Optional: define DMA_ARB_PRIO_EN to give channel 0 strict priority over the round-robin.
`timescale 1ns/1ps
module dma_axi_wr_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int MAX_OUTST = 4,
  parameter int ID_BITS   = 4,
  parameter int CH_W      = $clog2(NUM_CH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             ch_awvalid,
  output logic [NUM_CH-1:0]             ch_awready,
  input  logic [NUM_CH*32-1:0]          ch_awaddr,
  input  logic [NUM_CH*LEN_BITS-1:0]    ch_awlen,
  input  logic [NUM_CH*SIZE_BITS-1:0]   ch_awsize,
  input  logic [NUM_CH-1:0]             ch_wvalid,
  output logic [NUM_CH-1:0]             ch_wready,
  input  logic [NUM_CH*64-1:0]          ch_wdata,
  input  logic [NUM_CH*8-1:0]           ch_wstrb,
  input  logic [NUM_CH-1:0]             ch_wlast,
  output logic [NUM_CH-1:0]             ch_bvalid,
  input  logic [NUM_CH-1:0]             ch_bready,
  output logic [1:0]                    ch_bresp,
  output logic [ID_BITS-1:0]            awid,
  output logic [31:0]                   awaddr,
  output logic [LEN_BITS-1:0]           awlen,
  output logic [SIZE_BITS-1:0]          awsize,
  output logic                          awvalid,
  input  logic                          awready,
  output logic [ID_BITS-1:0]            wid,
  output logic [63:0]                   wdata,
  output logic [7:0]                    wstrb,
  output logic                          wlast,
  output logic                          wvalid,
  input  logic                          wready,
  input  logic [ID_BITS-1:0]            bid,
  input  logic [1:0]                    bresp,
  input  logic                          bvalid,
  output logic                          bready,
  output logic                          bid_err
);

  arb_state_e            r_state, w_state_next;
  logic [CH_W-1:0]       r_gnt, r_rr, w_pick, w_rr_next, w_bidx;
  logic [31:0]           r_awaddr;
  logic [LEN_BITS-1:0]   r_awlen;
  logic [SIZE_BITS-1:0]  r_awsize;
  logic                  r_bid_err;
  logic [NUM_CH-1:0]     w_full, w_elig, w_inc, w_dec;
  logic [MAX_CH-1:0]     w_req_ext;
  logic [ID_BITS-1:0]    w_id;
  logic                  w_any, w_aw_hs, w_wlast_hs, w_bid_ok, w_b_hs;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign w_elig[gi] = ch_awvalid[gi] & ~w_full[gi];
    assign w_inc[gi]  = w_aw_hs && (r_gnt == CH_W'(gi));
    assign w_dec[gi]  = w_b_hs && (w_bidx == CH_W'(gi));

    dma_outst_cnt #(
      .MAX_OUTST (MAX_OUTST)
    ) u_outst (
      .clk    (clk),
      .reset  (reset),
      .i_inc  (w_inc[gi]),
      .i_dec  (w_dec[gi]),
      .o_full (w_full[gi])
    );
  end

  assign w_any = |w_elig;

  always_comb begin
    w_req_ext              = '0;
    w_req_ext[NUM_CH-1:0]  = w_elig;
    w_pick = CH_W'(rr_pick(w_req_ext, 32'(r_rr), NUM_CH));
`ifdef DMA_ARB_PRIO_EN
    if (w_elig[0]) w_pick = '0;
`endif
  end

  always_comb begin
    w_rr_next = (r_gnt == CH_W'(NUM_CH - 1)) ? '0 : r_gnt + 1'b1;
`ifdef DMA_ARB_PRIO_EN
    if (r_gnt == '0) w_rr_next = r_rr;
`endif
  end

  // Internal handshakes use the ungated terms; reset holds every flop anyway.
  assign w_aw_hs    = (r_state == ADDR) & awready;
  assign w_wlast_hs = (r_state == DATA) & ch_wvalid[r_gnt] & wready & ch_wlast[r_gnt];

  always_comb begin
    w_state_next = r_state;
    ch_awready   = '0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    ch_wready    = '0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          ch_awready[w_pick] = reset;
          w_state_next       = ADDR;
        end
      end
      ADDR: begin
        awvalid = reset;
        if (awready) w_state_next = DATA;
      end
      DATA: begin
        wvalid            = ch_wvalid[r_gnt] & reset;
        ch_wready[r_gnt]  = wready & reset;
        if (w_wlast_hs) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_rr      <= '0;
      r_awaddr  <= '0;
      r_awlen   <= '0;
      r_awsize  <= '0;
      r_bid_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && w_any) begin
        r_gnt    <= w_pick;
        r_awaddr <= ch_awaddr[w_pick*32 +: 32];
        r_awlen  <= ch_awlen[w_pick*LEN_BITS +: LEN_BITS];
        r_awsize <= ch_awsize[w_pick*SIZE_BITS +: SIZE_BITS];
      end
      if (w_wlast_hs) r_rr <= w_rr_next;
      if (bvalid && !w_bid_ok) r_bid_err <= 1'b1;
    end
  end

  always_comb begin
    w_id             = '0;
    w_id[CH_W-1:0]   = r_gnt;
  end

  assign awid   = w_id;
  assign awaddr = r_awaddr;
  assign awlen  = r_awlen;
  assign awsize = r_awsize;
  assign wid    = w_id;
  assign wdata  = ch_wdata[r_gnt*64 +: 64];
  assign wstrb  = ch_wstrb[r_gnt*8 +: 8];
  assign wlast  = ch_wlast[r_gnt];

  // B path is purely combinational; out-of-range ids are swallowed.
  assign w_bid_ok = ({1'b0, bid} < (ID_BITS + 1)'(NUM_CH));
  assign w_bidx   = bid[CH_W-1:0];
  assign w_b_hs   = bvalid & w_bid_ok & ch_bready[w_bidx];
  assign bready   = reset & (w_bid_ok ? ch_bready[w_bidx] : 1'b1);
  assign ch_bresp = bresp;
  assign bid_err  = r_bid_err;

  always_comb begin
    ch_bvalid = '0;
    if (bvalid && w_bid_ok) ch_bvalid[w_bidx] = reset;
  end

endmodule

// File: tb/tb_dma_axi_wr_arbiter.sv
// Self-checking bench for dma_axi_wr_arbiter: directed scenarios plus randomized traffic vs a behavioural model.
`timescale 1ns/1ps
module tb_dma_axi_wr_arbiter;
  import dma_arb_pkg::*;

  localparam int NUM_CH    = 4;
  localparam int MAX_OUTST = 4;
  localparam int ID_BITS   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                         reset;
  logic [NUM_CH-1:0]            ch_awvalid, ch_awready, ch_wvalid, ch_wready, ch_wlast, ch_bvalid, ch_bready;
  logic [NUM_CH*32-1:0]         ch_awaddr;
  logic [NUM_CH*LEN_BITS-1:0]   ch_awlen;
  logic [NUM_CH*SIZE_BITS-1:0]  ch_awsize;
  logic [NUM_CH*64-1:0]         ch_wdata;
  logic [NUM_CH*8-1:0]          ch_wstrb;
  logic [1:0]                   ch_bresp, bresp;
  logic [ID_BITS-1:0]           awid, wid, bid;
  logic [31:0]                  awaddr;
  logic [LEN_BITS-1:0]          awlen;
  logic [SIZE_BITS-1:0]         awsize;
  logic [63:0]                  wdata;
  logic [7:0]                   wstrb;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready, bid_err;

  dma_axi_wr_arbiter #(.NUM_CH(NUM_CH), .MAX_OUTST(MAX_OUTST), .ID_BITS(ID_BITS)) dut (
    .clk(clk), .reset(reset),
    .ch_awvalid(ch_awvalid), .ch_awready(ch_awready), .ch_awaddr(ch_awaddr),
    .ch_awlen(ch_awlen), .ch_awsize(ch_awsize),
    .ch_wvalid(ch_wvalid), .ch_wready(ch_wready), .ch_wdata(ch_wdata),
    .ch_wstrb(ch_wstrb), .ch_wlast(ch_wlast),
    .ch_bvalid(ch_bvalid), .ch_bready(ch_bready), .ch_bresp(ch_bresp),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready), .bid_err(bid_err)
  );

  int tests = 0;
  int fails = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Model: phase 0 = awaiting grant, 1 = address pending, 2 = data
  int m_phase, m_cur, m_rr;
  int m_outst[NUM_CH];
  bit m_err;
  logic [31:0]          m_addr;
  logic [LEN_BITS-1:0]  m_len;
  logic [SIZE_BITS-1:0] m_size;

  int grants[$];
  int grant_cyc[$];
  int cyc = 0;

  logic [NUM_CH-1:0] s_ch_awready, s_ch_wready, s_ch_bvalid;
  logic s_awvalid, s_wvalid, s_bready, s_bid_err;
  logic [ID_BITS-1:0] s_awid;
  logic [31:0] s_awaddr;
  logic [LEN_BITS-1:0] s_awlen;

  function automatic void model_reset();
    m_phase = 0; m_cur = 0; m_rr = 0; m_err = 0;
    m_addr = '0; m_len = '0; m_size = '0;
    for (int i = 0; i < NUM_CH; i++) m_outst[i] = 0;
  endfunction

  function automatic int pick(logic [NUM_CH-1:0] elig);
`ifdef DMA_ARB_PRIO_EN
    if (elig[0]) return 0;
`endif
    for (int k = 0; k < NUM_CH; k++)
      if (elig[(m_rr + k) % NUM_CH]) return (m_rr + k) % NUM_CH;
    return -1;
  endfunction

  function automatic int getg(int k);
    return (grants.size() > k) ? grants[k] : -1;
  endfunction

  task automatic idle_inputs();
    ch_awvalid = '0; ch_awaddr = '0; ch_awlen = '0; ch_awsize = '0;
    ch_wvalid = '0; ch_wdata = '0; ch_wstrb = '0; ch_wlast = '0; ch_bready = '0;
    awready = 0; wready = 0; bid = '0; bresp = RESP_OKAY; bvalid = 0;
  endtask

  task automatic clear_log();
    grants.delete();
    grant_cyc.delete();
  endtask

  // Called at negedge with inputs applied: compare outputs, advance the model, move to next negedge.
  task automatic cycle();
    logic [NUM_CH-1:0] elig, e_awready, e_wready, e_bvalid;
    logic e_awvalid, e_wvalid, e_bready, bok;
    int g, b, inc;
    #1;
    for (int i = 0; i < NUM_CH; i++) elig[i] = ch_awvalid[i] && (m_outst[i] < MAX_OUTST);
    g = (m_phase == 0) ? pick(elig) : -1;
    e_awready = '0;
    if (g >= 0) e_awready[g] = 1'b1;
    e_awvalid = (m_phase == 1);
    e_wvalid  = (m_phase == 2) && ch_wvalid[m_cur];
    e_wready  = '0;
    if (m_phase == 2) e_wready[m_cur] = wready;
    bok = (bid < NUM_CH);
    e_bvalid = '0;
    if (bvalid && bok) e_bvalid[bid] = 1'b1;
    e_bready = bok ? ch_bready[bid] : 1'b1;

    chk("ch_awready", ch_awready, e_awready);
    chk("awvalid", awvalid, e_awvalid);
    chk("wvalid", wvalid, e_wvalid);
    chk("ch_wready", ch_wready, e_wready);
    chk("ch_bvalid", ch_bvalid, e_bvalid);
    chk("bready", bready, e_bready);
    chk("bid_err", bid_err, m_err);
    if (e_awvalid) begin
      chk("awaddr", awaddr, m_addr);
      chk("awlen", awlen, m_len);
      chk("awsize", awsize, m_size);
      chk("awid", awid, m_cur);
    end
    if (e_wvalid) begin
      chk("wdata", wdata, ch_wdata[m_cur*64 +: 64]);
      chk("wstrb", wstrb, ch_wstrb[m_cur*8 +: 8]);
      chk("wlast", wlast, ch_wlast[m_cur]);
      chk("wid", wid, m_cur);
    end
    if (bvalid) chk("ch_bresp", ch_bresp, bresp);

    for (int i = 0; i < NUM_CH; i++)
      if (ch_awready[i]) begin grants.push_back(i); grant_cyc.push_back(cyc); end
    s_ch_awready = ch_awready; s_ch_wready = ch_wready; s_ch_bvalid = ch_bvalid;
    s_awvalid = awvalid; s_wvalid = wvalid; s_bready = bready; s_bid_err = bid_err;
    s_awid = awid; s_awaddr = awaddr; s_awlen = awlen;

    b = (bvalid && bok && ch_bready[bid]) ? int'(bid) : -1;
    inc = -1;
    case (m_phase)
      0: if (g >= 0) begin
           m_cur = g; m_phase = 1;
           m_addr = ch_awaddr[g*32 +: 32];
           m_len  = ch_awlen[g*LEN_BITS +: LEN_BITS];
           m_size = ch_awsize[g*SIZE_BITS +: SIZE_BITS];
         end
      1: if (awready) begin inc = m_cur; m_phase = 2; end
      default: if (ch_wvalid[m_cur] && wready && ch_wlast[m_cur]) begin
`ifdef DMA_ARB_PRIO_EN
           if (m_cur != 0)
`endif
           m_rr = (m_cur + 1) % NUM_CH;
           m_phase = 0;
         end
    endcase
    if (inc >= 0) m_outst[inc]++;
    if (b >= 0) m_outst[b]--;
    if (bvalid && !bok) m_err = 1;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    idle_inputs();
    #1;
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_bid_err", bid_err, 1'b0);
    chk("rst_awaddr", awaddr, 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  int bpct;
  int off;

  initial begin
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    apply_reset();

    // Single ch2 burst, 4 beats, then its B response
    ch_awvalid = 4'b0100;
    ch_awaddr[2*32 +: 32] = 32'h0000_1000;
    ch_awlen[2*LEN_BITS +: LEN_BITS] = 4'd3;
    ch_awsize[2*SIZE_BITS +: SIZE_BITS] = 3'd3;
    cycle();
    chk("t1_ch_awready", s_ch_awready, 4'b0100);
    ch_awvalid = '0; awready = 1;
    cycle();
    chk("t1_awvalid", s_awvalid, 1'b1);
    chk("t1_awid", s_awid, 2);
    chk("t1_awaddr", s_awaddr, 32'h0000_1000);
    chk("t1_awlen", s_awlen, 3);
    awready = 0; wready = 1; ch_wvalid = 4'b0100;
    for (int beat = 0; beat < 4; beat++) begin
      ch_wlast = (beat == 3) ? 4'b0100 : 4'b0000;
      ch_wdata[2*64 +: 64] = 64'hA000 + 64'(beat);
      cycle();
      chk("t1_ch_wready", s_ch_wready, 4'b0100);
      chk("t1_wvalid", s_wvalid, 1'b1);
    end
    ch_wvalid = '0; ch_wlast = '0; wready = 0;
    chk("t1_outst_one", m_outst[2], 1);
    bvalid = 1; bid = 4'd2; ch_bready = 4'b0100;
    cycle();
    chk("t1_ch_bvalid", s_ch_bvalid, 4'b0100);
    chk("t1_bready", s_bready, 1'b1);
    bvalid = 0; ch_bready = '0;
    chk("t1_outst_zero", m_outst[2], 0);

    // All four channels requesting continuously, one-beat bursts
    apply_reset();
    clear_log();
    ch_awvalid = 4'hF; awready = 1; wready = 1; ch_wvalid = 4'hF; ch_wlast = 4'hF;
    repeat (15) cycle();
    for (int k = 0; k < 5; k++) chk("t2_order", getg(k), (k % 4));
    for (int k = 1; k < 5; k++)
      chk("t2_gap", (grant_cyc.size() > k) ? grant_cyc[k] - grant_cyc[k-1] : -1, 3);

    // Ch1 fills its outstanding budget; ch3 still served; one B frees ch1
    apply_reset();
    clear_log();
    ch_awvalid = 4'b0010; awready = 1; wready = 1; ch_wvalid = 4'hF; ch_wlast = 4'hF;
    repeat (12) cycle();
    chk("t3_ch1_bursts", grants.size(), 4);
    chk("t3_outst_full", m_outst[1], MAX_OUTST);
    clear_log();
    ch_awvalid = 4'b1010;
    repeat (9) cycle();
    chk("t3_blocked_first", getg(0), 3);
    chk("t3_blocked_count", grants.size(), 3);
    for (int k = 0; k < 3; k++) chk("t3_only_ch3", getg(k), 3);
    clear_log();
    ch_awvalid = 4'b0010; bvalid = 1; bid = 4'd1; ch_bready = 4'b0010;
    cycle();
    bvalid = 0; ch_bready = '0;
    repeat (6) cycle();
    chk("t3_ch1_resumes", getg(0), 1);

    // Same-cycle AW and B handshake on ch0 at two outstanding
    apply_reset();
    ch_awvalid = 4'b0001; awready = 1; wready = 1; ch_wvalid = 4'b0001; ch_wlast = 4'b0001;
    repeat (6) cycle();
    chk("t4_outst_two", m_outst[0], 2);
    awready = 0;
    cycle();
    ch_awvalid = '0; awready = 1; bvalid = 1; bid = 4'd0; ch_bready = 4'b0001;
    cycle();
    chk("t4_awvalid", s_awvalid, 1'b1);
    chk("t4_bready", s_bready, 1'b1);
    bvalid = 0; ch_bready = '0; awready = 0;
    chk("t4_outst_hold", m_outst[0], 2);
    cycle();
    clear_log();
    ch_awvalid = 4'b0001; awready = 1;
    repeat (9) cycle();
    chk("t4_until_full", grants.size(), 2);

    // Illegal bid
    ch_awvalid = '0;
    bvalid = 1; bid = 4'd7; ch_bready = '0; bresp = RESP_SLVERR;
    cycle();
    chk("t5_bready", s_bready, 1'b1);
    chk("t5_no_bvalid", s_ch_bvalid, 4'b0000);
    bvalid = 0; bid = '0;
    cycle();
    chk("t5_bid_err", s_bid_err, 1'b1);
    repeat (3) cycle();
    chk("t5_bid_err_sticky", s_bid_err, 1'b1);
    apply_reset();
    cycle();
    chk("t5_bid_err_clr", s_bid_err, 1'b0);

    // Reset in the middle of a ch2 data phase after two beats
    ch_awvalid = 4'b0010; awready = 1; wready = 1; ch_wvalid = 4'b0010; ch_wlast = 4'b0010;
    repeat (3) cycle();
    ch_awvalid = 4'b0100; ch_wvalid = 4'b0100; ch_wlast = '0;
    cycle();
    ch_awvalid = '0;
    repeat (3) cycle();
    ch_awvalid = 4'b0101;
    #2;
    reset = 1'b0;
    #1;
    chk("t6_awvalid", awvalid, 1'b0);
    chk("t6_wvalid", wvalid, 1'b0);
    chk("t6_ch_wready", ch_wready, 4'b0000);
    chk("t6_ch_awready", ch_awready, 4'b0000);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    ch_wvalid = '0; awready = 0; wready = 0;
    cycle();
    chk("t6_grant_rr0", s_ch_awready, 4'b0001);
    ch_awvalid = '0;
    repeat (2) cycle();

    // Channels 0 and 1 both requesting
    apply_reset();
    clear_log();
    ch_awvalid = 4'b0011; awready = 1; wready = 1; ch_wvalid = 4'b0011; ch_wlast = 4'b0011;
    repeat (12) cycle();
    for (int k = 0; k < 4; k++) begin
`ifdef DMA_ARB_PRIO_EN
      chk("t7_prio", getg(k), 0);
`else
      chk("t7_rr", getg(k), k % 2);
`endif
    end

    // Randomized traffic against the model
    apply_reset();
    for (int seg = 0; seg < 8; seg++) begin
      bpct = (seg % 2 == 1) ? 5 : 60;
      for (int n = 0; n < 250; n++) begin
        ch_awvalid = 4'($urandom);
        ch_awaddr  = {$urandom, $urandom, $urandom, $urandom};
        ch_awlen   = 16'($urandom);
        ch_awsize  = 12'($urandom);
        for (int i = 0; i < NUM_CH; i++) begin
          ch_wvalid[i] = ($urandom_range(0, 3) != 0);
          ch_wlast[i]  = ($urandom_range(0, 2) == 0);
          ch_wdata[i*64 +: 64] = {$urandom, $urandom};
        end
        ch_wstrb  = $urandom;
        ch_bready = 4'($urandom);
        awready   = ($urandom_range(0, 3) != 0);
        wready    = ($urandom_range(0, 3) != 0);
        bresp     = ($urandom_range(0, 1) == 1) ? RESP_SLVERR : RESP_OKAY;
        bvalid    = 0;
        bid       = '0;
        if ($urandom_range(0, 99) < bpct) begin
          if ($urandom_range(0, 19) == 0) begin
            bvalid = 1;
            bid = 4'($urandom_range(NUM_CH, 15));
          end else begin
            off = $urandom_range(0, NUM_CH - 1);
            for (int k = 0; k < NUM_CH; k++)
              if (!bvalid && m_outst[(off + k) % NUM_CH] > 0) begin
                bvalid = 1;
                bid = 4'((off + k) % NUM_CH);
              end
          end
        end
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
